// File: rtl/i2s_mic_ctrl_pkg.sv
// ============================================================================
// Module   : i2s_pkg
// Brief    : Shared types and frame geometry for the I2S microphone controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam int FRAME_BITS  = 64;
    localparam int SLOT_BITS   = 32;
    localparam int SAMPLE_W    = 16;
    localparam int BIT_IDX_W   = $clog2(FRAME_BITS);

    localparam int LEFT_MSB_B  = 1;
    localparam int RIGHT_MSB_B = 33;
    localparam int LEFT_LSB_B  = LEFT_MSB_B + SAMPLE_W - 1;
    localparam int RIGHT_LSB_B = RIGHT_MSB_B + SAMPLE_W - 1;

    // True when bit index b falls inside the 16-bit window starting at msb.
    function automatic logic in_window(input logic [BIT_IDX_W-1:0] b, input int msb);
        return (int'(b) >= msb) && (int'(b) <= msb + SAMPLE_W - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_mic_ctrl_clkgen.sv
// ============================================================================
// Module   : i2s_clkgen
// Brief    : BCLK/LRCL generator with BCLK-rise strobe and frame bit index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 24
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 enable_in,
    output logic                 bclk_out,
    output logic                 lrcl_out,
    output logic                 rise_out,
    output logic                 wrap_out,
    output logic [BIT_IDX_W-1:0] bit_idx_out
);

    localparam int                DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  c_DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_IDX_W-1:0] c_LAST_LEFT = BIT_IDX_W'(SLOT_BITS - 1);
    localparam logic [BIT_IDX_W-1:0] c_LAST_BIT  = BIT_IDX_W'(FRAME_BITS - 1);

    logic [DIV_W-1:0]     r_div;
    logic                 r_bclk;
    logic                 r_lrcl;
    logic                 r_started;
    logic [BIT_IDX_W-1:0] r_bit;
    logic                 w_tick;
    logic                 w_rise;
    logic                 w_fall;

    assign w_tick = (r_div == c_DIV_MAX);
    assign w_rise = enable_in && w_tick && !r_bclk;
    assign w_fall = enable_in && w_tick && r_bclk;

    // r_started distinguishes the very first rise (b=0) from later ones.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_div     <= '0;
            r_bclk    <= 1'b0;
            r_lrcl    <= 1'b0;
            r_started <= 1'b0;
            r_bit     <= '0;
        end else if (!enable_in) begin
            r_div     <= '0;
            r_bclk    <= 1'b0;
            r_lrcl    <= 1'b0;
            r_started <= 1'b0;
            r_bit     <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_bclk <= !r_bclk;
            end
            if (w_rise) begin
                r_started <= 1'b1;
                if (r_started) begin
                    r_bit <= r_bit + 1'b1;
                end
            end
            if (w_fall) begin
                if (r_bit == c_LAST_LEFT) begin
                    r_lrcl <= 1'b1;
                end else if (r_bit == c_LAST_BIT) begin
                    r_lrcl <= 1'b0;
                end
            end
        end
    end

    // Index of the bit being captured by the rise happening this cycle.
    assign bit_idx_out = r_started ? r_bit + 1'b1 : '0;
    assign rise_out    = w_rise;
    assign wrap_out    = w_rise && r_started && (r_bit == c_LAST_BIT);
    assign bclk_out    = r_bclk;
    assign lrcl_out    = r_lrcl;

endmodule

`default_nettype wire

// File: rtl/i2s_mic_ctrl.sv
// ============================================================================
// Module   : i2s_mic_ctrl
// Brief    : I2S MEMS mic sequencer, deserializer and valid/ready output stage.
//            Define I2S_STEREO_EN to also capture and deliver the right slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_mic_ctrl
    import i2s_pkg::*;
#(
    parameter int CLK_DIV       = 24,
    parameter int WARMUP_FRAMES = 4096
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                enable_in,
    input  logic                mic_data_in,
    output logic                bclk_out,
    output logic                lrcl_out,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid_out,
    input  logic                sample_ready_in,
    output logic                channel_out,
    output logic                overrun_out,
    output logic [1:0]          state_out
);

    localparam int FC_W = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;
    localparam logic [FC_W-1:0] c_WARM_LAST =
        FC_W'((WARMUP_FRAMES > 0) ? WARMUP_FRAMES - 1 : 0);
    localparam logic [BIT_IDX_W-1:0] c_LEFT_LSB  = BIT_IDX_W'(LEFT_LSB_B);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [FC_W-1:0]      r_frames;
    logic                 w_clk_en;
    logic                 w_rise;
    logic                 w_wrap;
    logic [BIT_IDX_W-1:0] w_cap_idx;
    logic                 w_warm_done;
    logic                 w_cap;
    logic [SAMPLE_W-1:0]  r_shift;
    logic                 r_done;
    logic                 r_done_ch;
    logic [SAMPLE_W-1:0]  r_sample;
    logic                 r_valid;
    logic                 r_ovr;
    logic                 w_new;
    logic                 w_xfer;

    // Gating on enable_in directly stops the clocks on the same edge as IDLE entry.
    assign w_clk_en = enable_in && (r_state != IDLE);

    i2s_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .enable_in   (w_clk_en),
        .bclk_out    (bclk_out),
        .lrcl_out    (lrcl_out),
        .rise_out    (w_rise),
        .wrap_out    (w_wrap),
        .bit_idx_out (w_cap_idx)
    );

    assign w_warm_done = (WARMUP_FRAMES == 0) || (w_wrap && (r_frames == c_WARM_LAST));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable_in) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = WARMUP;
                WARMUP:  if (w_warm_done) w_state_nxt = RUN;
                RUN:     w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_frames <= '0;
        end else if (r_state != WARMUP) begin
            r_frames <= '0;
        end else if (w_wrap) begin
            r_frames <= r_frames + 1'b1;
        end
    end

`ifdef I2S_STEREO_EN
    localparam logic [BIT_IDX_W-1:0] c_RIGHT_LSB = BIT_IDX_W'(RIGHT_LSB_B);
    assign w_cap = w_rise && (in_window(w_cap_idx, LEFT_MSB_B) ||
                              in_window(w_cap_idx, RIGHT_MSB_B));
`else
    assign w_cap = w_rise && in_window(w_cap_idx, LEFT_MSB_B);
`endif

    // r_done pulses the cycle after the LSB is shifted in; r_done_ch tags its slot.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_shift   <= '0;
            r_done    <= 1'b0;
            r_done_ch <= 1'b0;
        end else if (!w_clk_en) begin
            r_shift   <= '0;
            r_done    <= 1'b0;
            r_done_ch <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_cap) begin
                r_shift <= {r_shift[SAMPLE_W-2:0], mic_data_in};
                if (w_cap_idx == c_LEFT_LSB) begin
                    r_done    <= 1'b1;
                    r_done_ch <= 1'b0;
                end
`ifdef I2S_STEREO_EN
                if (w_cap_idx == c_RIGHT_LSB) begin
                    r_done    <= 1'b1;
                    r_done_ch <= 1'b1;
                end
`endif
            end
        end
    end

    assign w_new  = r_done && enable_in && (r_state == RUN);
    assign w_xfer = r_valid && sample_ready_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_ovr    <= 1'b0;
        end else if (!enable_in || (r_state == IDLE)) begin
            r_valid  <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (w_new) begin
                r_sample <= r_shift;
                r_valid  <= 1'b1;
                if (r_valid && !sample_ready_in) begin
                    r_ovr <= 1'b1;
                end
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef I2S_STEREO_EN
    logic r_ch;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ch <= 1'b0;
        end else if (w_new) begin
            r_ch <= r_done_ch;
        end
    end

    assign channel_out = r_ch;
`else
    assign channel_out = 1'b0;
`endif

    assign sample_out       = r_sample;
    assign sample_valid_out = r_valid;
    assign overrun_out      = r_ovr;
    assign state_out        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_i2s_mic_ctrl.sv
// ============================================================================
// Module   : tb_i2s_mic_ctrl
// Brief    : Self-checking bench for i2s_mic_ctrl (CLK_DIV=4, WARMUP_FRAMES=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2s_mic_ctrl;

    localparam int CLK_DIV       = 4;
    localparam int WARMUP_FRAMES = 2;

    logic        clk_in          = 1'b0;
    logic        rst_n_in        = 1'b1;
    logic        enable_in       = 1'b0;
    logic        mic_data_in     = 1'b0;
    logic        sample_ready_in = 1'b1;
    logic        bclk_out;
    logic        lrcl_out;
    logic [15:0] sample_out;
    logic        sample_valid_out;
    logic        channel_out;
    logic        overrun_out;
    logic [1:0]  state_out;

    int          total   = 0;
    int          bad     = 0;
    int          ovr_cnt = 0;
    logic [16:0] expq[$];

    always #5 clk_in = ~clk_in;

    i2s_mic_ctrl #(
        .CLK_DIV       (CLK_DIV),
        .WARMUP_FRAMES (WARMUP_FRAMES)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .enable_in        (enable_in),
        .mic_data_in      (mic_data_in),
        .bclk_out         (bclk_out),
        .lrcl_out         (lrcl_out),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out),
        .sample_ready_in  (sample_ready_in),
        .channel_out      (channel_out),
        .overrun_out      (overrun_out),
        .state_out        (state_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every handshake pops one expected {channel, sample}.
    always @(negedge clk_in) begin
        if (rst_n_in && sample_valid_out && sample_ready_in) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL xfer_unexpected act=%0h exp=none", {channel_out, sample_out});
            end else begin
                logic [16:0] e;
                e = expq.pop_front();
                if ({channel_out, sample_out} !== e) begin
                    bad++;
                    $display("FAIL xfer act=%0h exp=%0h", {channel_out, sample_out}, e);
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (rst_n_in && overrun_out) ovr_cnt++;
    end

    task automatic wait_rise(output int n);
        logic prev;
        prev = bclk_out;
        n = 0;
        forever begin
            @(posedge clk_in); #1;
            n++;
            if (!prev && bclk_out) return;
            prev = bclk_out;
            if (n >= 40) begin
                check("rise_timeout", n, 0);
                return;
            end
        end
    endtask

    function automatic logic bit_val(input int b, input logic [15:0] l, input logic [15:0] r);
        if (b >= 1 && b <= 16) return l[16-b];
        if (b >= 33 && b <= 48) return r[48-b];
        return logic'(b % 3 == 0);
    endfunction

    // Drives one frame bit by bit; stop_b ends the frame early after that rise.
    task automatic frame(input logic [15:0] l, input logic [15:0] r, input int exp_state,
                         input bit push, input bit lat, input int stop_b);
        int n;
        if (push) begin
            expq.push_back({1'b0, l});
`ifdef I2S_STEREO_EN
            expq.push_back({1'b1, r});
`endif
        end
        for (int b = 0; b < 64; b++) begin
            mic_data_in = bit_val(b, l, r);
            wait_rise(n);
            if (b == 0) check("frame_state", state_out, exp_state);
            if (b == stop_b) return;
            if (lat && b == 16) begin
                check("lat_pre_valid", sample_valid_out, 0);
                @(posedge clk_in); #1;
                check("lat_valid", sample_valid_out, 1);
                check("lat_sample", sample_out, l);
                check("lat_chan", channel_out, 0);
                @(posedge clk_in); #1;
                check("lat_drop", sample_valid_out, 0);
            end
        end
    endtask

    initial begin
        int n;
        #2 rst_n_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_clocks", {bclk_out, lrcl_out}, 0);
        check("rst_valid", {sample_valid_out, overrun_out, channel_out}, 0);
        check("rst_state", state_out, 0);
        check("rst_sample", sample_out, 0);

        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        check("idle_hold", state_out, 0);

        // Clock generation over the first (discarded) frame
        enable_in = 1'b1;
        @(posedge clk_in); #1;
        check("enter_warmup", state_out, 1);
        n = 0;
        while (!bclk_out && n < 40) begin
            @(posedge clk_in); #1;
            n++;
        end
        check("first_rise_delay", n, CLK_DIV);
        check("lrcl_b0", lrcl_out, 0);
        for (int k = 1; k < 64; k++) begin
            mic_data_in = bit_val(k, 16'hFFFF, 16'hFFFF);
            wait_rise(n);
            check("bclk_period", n, 2 * CLK_DIV);
            check("lrcl_slot", lrcl_out, (k >= 32));
        end

        // Second warm-up frame discarded, third frame delivered
        frame(16'h1111, 16'h2222, 1, 1'b0, 1'b0, -1);
        frame(16'hA5C3, 16'h3C5A, 2, 1'b1, 1'b1, -1);
        frame(16'h5A3C, 16'h0FF0, 2, 1'b1, 1'b1, -1);

        // Backpressure across two frames
        sample_ready_in = 1'b0;
`ifdef I2S_STEREO_EN
        expq.push_back({1'b1, 16'h7F00});
`else
        expq.push_back({1'b0, 16'h8000});
`endif
        frame(16'h1234, 16'h4321, 2, 1'b0, 1'b0, -1);
        frame(16'h8000, 16'h7F00, 2, 1'b0, 1'b0, -1);
`ifdef I2S_STEREO_EN
        check("ovr_count", ovr_cnt, 3);
        check("bp_sample", sample_out, 16'h7F00);
`else
        check("ovr_count", ovr_cnt, 1);
        check("bp_sample", sample_out, 16'h8000);
`endif
        check("bp_valid_held", sample_valid_out, 1);
        sample_ready_in = 1'b1;
        @(posedge clk_in); #1;
        check("bp_valid_drop", sample_valid_out, 0);

        // Pending sample plus partial frame, then disable at b=10
        sample_ready_in = 1'b0;
        frame(16'h0F0F, 16'hF0F0, 2, 1'b0, 1'b0, -1);
        check("pend_valid", sample_valid_out, 1);
        frame(16'hFFFF, 16'hFFFF, 2, 1'b0, 1'b0, 10);
        enable_in = 1'b0;
        @(posedge clk_in); #1;
        check("dis_clocks", {bclk_out, lrcl_out}, 0);
        check("dis_state", state_out, 0);
        check("dis_valid", sample_valid_out, 0);
        sample_ready_in = 1'b1;
        repeat (20) @(posedge clk_in);
        #1;
        check("dis_quiet", {sample_valid_out, bclk_out}, 0);

        // Re-enable restarts warm-up from zero
        enable_in = 1'b1;
        @(posedge clk_in); #1;
        check("reen_warmup", state_out, 1);
        frame(16'h0000, 16'h0000, 1, 1'b0, 1'b0, -1);
        frame(16'hBEEF, 16'hCAFE, 1, 1'b0, 1'b0, -1);
        frame(16'h7FFF, 16'h8001, 2, 1'b1, 1'b1, -1);
        repeat (4) @(posedge clk_in);
        #1;
        check("queue_empty", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
